// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types and helpers for the N-approach traffic phase sequencer:
// stage encoding, phase-index width, one-hot decode and round-robin search.
package traffic_pkg;

    localparam logic [1:0] STG_GREEN   = 2'd0;
    localparam logic [1:0] STG_YELLOW  = 2'd1;
    localparam logic [1:0] STG_ALL_RED = 2'd2;
    localparam int         MAX_PHASES  = 8;

    typedef enum logic [1:0] {
        GREEN   = STG_GREEN,
        YELLOW  = STG_YELLOW,
        ALL_RED = STG_ALL_RED
    } stage_t;

    function automatic int ph_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_PHASES-1:0] onehot(input logic [2:0] idx);
        return MAX_PHASES'(1) << idx;
    endfunction

    // First pending approach after cur (wrapping, cur itself last); cur+1 if none.
    function automatic logic [2:0] next_pending(input logic [MAX_PHASES-1:0] pend,
                                                input logic [2:0] cur, input int n);
        logic [2:0] nxt;
        logic       found;
        int         idx;
        nxt   = 3'((int'(cur) + 1) % n);
        found = 1'b0;
        for (int k = 1; k <= MAX_PHASES; k++) begin
            idx = (int'(cur) + k) % n;
            if (!found && k <= n && pend[idx[2:0]]) begin
                nxt   = idx[2:0];
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_tick_prescaler.sv
// Free-running divider producing a registered one-cycle pulse every TICK_DIV clocks;
// also used by the display refresh logic.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int W = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);

    logic [W-1:0] count;

    // The pulse is registered one count early so it lines up with count == TICK_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            if (count == W'(TICK_DIV - 1))
                count <= '0;
            else
                count <= count + W'(1);
            if (TICK_DIV == 1)
                tick <= 1'b1;
            else
                tick <= (count == W'(TICK_DIV - 2));
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Round-robin GREEN->YELLOW->ALL_RED sequencer for NUM_PHASES approaches, stepped by a 1 s tick.
// Optional feature: define EARLY_GAPOUT_EN to truncate an idle green to GAP_T when others wait.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int TICK_DIV   = 50_000_000,
    parameter int CNT_W      = 8,
    parameter int GREEN_T    = 27,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int GAP_T      = 5,
    localparam int PH_W      = ph_w(NUM_PHASES)
) (
    input  logic                  clk_50M,
    input  logic                  reset_n,
    input  logic [NUM_PHASES-1:0] demand,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [PH_W-1:0]       cur_phase,
    output logic [1:0]            stage,
    output logic [CNT_W-1:0]      countdown,
    output logic                  tick_1s
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (NUM_PHASES < 1 || NUM_PHASES > MAX_PHASES) begin : g_bad_phases
        $error("NUM_PHASES must be 1..8");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("TICK_DIV must be at least 1");
    end
    if (GREEN_T < 1 || GREEN_T > CNT_MAX || YELLOW_T < 1 || YELLOW_T > CNT_MAX ||
        ALLRED_T < 1 || ALLRED_T > CNT_MAX || GAP_T < 1 || GAP_T > CNT_MAX) begin : g_bad_dur
        $error("stage durations must fit 1..2^CNT_W-1");
    end

    stage_t                state;
    logic [NUM_PHASES-1:0] pending;
    logic [NUM_PHASES-1:0] pend_lat;
    logic [NUM_PHASES-1:0] cur_oh;
    logic [NUM_PHASES-1:0] next_oh;
    logic [2:0]            cur3;
    logic [2:0]            next3;
    logic                  others_req;
    logic                  gap_out;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk_50M),
        .reset_n (reset_n),
        .tick    (tick_1s)
    );

    assign stage = state;

    // Demand on the current cycle is folded in so a request on the expiry tick counts.
    always_comb begin
        pend_lat   = pending | demand;
        cur3       = 3'(cur_phase);
        cur_oh     = NUM_PHASES'(onehot(cur3));
        others_req = |(pend_lat & ~cur_oh);
        next3      = next_pending(MAX_PHASES'(pend_lat), cur3, NUM_PHASES);
        next_oh    = NUM_PHASES'(onehot(next3));
`ifdef EARLY_GAPOUT_EN
        gap_out    = !(|(demand & cur_oh)) && others_req && (countdown > CNT_W'(GAP_T));
`else
        gap_out    = 1'b0;
`endif
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state     <= GREEN;
            cur_phase <= '0;
            countdown <= CNT_W'(GREEN_T);
            green     <= NUM_PHASES'(1);
            yellow    <= '0;
            red       <= ~NUM_PHASES'(1);
            pending   <= '0;
        end else begin
            // The served approach never keeps a request while it is green.
            pending <= (state == GREEN) ? (pend_lat & ~cur_oh) : pend_lat;
            if (tick_1s) begin
                case (state)
                    GREEN: begin
                        if (countdown == CNT_W'(1)) begin
                            if (others_req) begin
                                state     <= YELLOW;
                                countdown <= CNT_W'(YELLOW_T);
                                green     <= '0;
                                yellow    <= cur_oh;
                                red       <= ~cur_oh;
                            end else begin
                                countdown <= CNT_W'(GREEN_T);
                            end
                        end else if (gap_out) begin
                            countdown <= CNT_W'(GAP_T);
                        end else begin
                            countdown <= countdown - CNT_W'(1);
                        end
                    end
                    YELLOW: begin
                        if (countdown == CNT_W'(1)) begin
                            state     <= ALL_RED;
                            countdown <= CNT_W'(ALLRED_T);
                            yellow    <= '0;
                            red       <= '1;
                        end else begin
                            countdown <= countdown - CNT_W'(1);
                        end
                    end
                    ALL_RED: begin
                        if (countdown == CNT_W'(1)) begin
                            state     <= GREEN;
                            cur_phase <= PH_W'(next3);
                            countdown <= CNT_W'(GREEN_T);
                            green     <= next_oh;
                            red       <= ~next_oh;
                            pending   <= pend_lat & ~next_oh;
                        end else begin
                            countdown <= countdown - CNT_W'(1);
                        end
                    end
                    default: begin
                        state     <= GREEN;
                        countdown <= CNT_W'(GREEN_T);
                        green     <= cur_oh;
                        yellow    <= '0;
                        red       <= ~cur_oh;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer with 2-, 4- and 1-approach instances (TICK_DIV=10).
module tb_traffic_phase_sequencer;

    localparam int TDIV = 10;

    logic clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    logic       reset_n;
    logic [1:0] demand2, green2, yellow2, red2, stage2;
    logic [0:0] cur2;
    logic [7:0] cd2;
    logic       tick2;

    logic [3:0] demand4, green4, yellow4, red4;
    logic [1:0] cur4, stage4;
    logic [7:0] cd4;
    logic       tick4;

    logic [0:0] demand1, green1, yellow1, red1, cur1;
    logic [1:0] stage1;
    logic [7:0] cd1;
    logic       tick1;

    traffic_phase_sequencer #(.NUM_PHASES(2), .TICK_DIV(TDIV)) dut2 (
        .clk_50M(clk_50M), .reset_n(reset_n), .demand(demand2), .green(green2), .yellow(yellow2),
        .red(red2), .cur_phase(cur2), .stage(stage2), .countdown(cd2), .tick_1s(tick2));

    traffic_phase_sequencer #(.NUM_PHASES(4), .TICK_DIV(TDIV)) dut4 (
        .clk_50M(clk_50M), .reset_n(reset_n), .demand(demand4), .green(green4), .yellow(yellow4),
        .red(red4), .cur_phase(cur4), .stage(stage4), .countdown(cd4), .tick_1s(tick4));

    traffic_phase_sequencer #(.NUM_PHASES(1), .TICK_DIV(TDIV)) dut1 (
        .clk_50M(clk_50M), .reset_n(reset_n), .demand(demand1), .green(green1), .yellow(yellow1),
        .red(red1), .cur_phase(cur1), .stage(stage1), .countdown(cd1), .tick_1s(tick1));

    int checks   = 0;
    int failures = 0;

    logic [36:0] q1[$];
    logic [36:0] q2[$];
    logic [36:0] q4[$];

    // Expected output word {phase, stage, countdown, green, yellow, red} for an n-approach build.
    function automatic logic [36:0] mk(int n, int ph, int st, int cd);
        logic [7:0] oh, g, y, r, all;
        oh  = 8'(1) << ph;
        all = 8'((1 << n) - 1);
        g   = (st == 0) ? oh : 8'h00;
        y   = (st == 1) ? oh : 8'h00;
        r   = all & ~(g | y);
        return {3'(ph), 2'(st), 8'(cd), g, y, r};
    endfunction

    function automatic logic [36:0] obs2();
        return {3'(cur2), stage2, cd2, 8'(green2), 8'(yellow2), 8'(red2)};
    endfunction
    function automatic logic [36:0] obs4();
        return {3'(cur4), stage4, cd4, 8'(green4), 8'(yellow4), 8'(red4)};
    endfunction
    function automatic logic [36:0] obs1();
        return {3'(cur1), stage1, cd1, 8'(green1), 8'(yellow1), 8'(red1)};
    endfunction

    function automatic void push(int which, logic [36:0] v);
        case (which)
            1:       q1.push_back(v);
            2:       q2.push_back(v);
            default: q4.push_back(v);
        endcase
    endfunction

    // One full service of phase ph after it has just entered green, handing over to nxt.
    function automatic void push_serve(int which, int n, int ph, int nxt);
        for (int c = 26; c >= 1; c--) push(which, mk(n, ph, 0, c));
        for (int c = 3; c >= 1; c--) push(which, mk(n, ph, 1, c));
        push(which, mk(n, ph, 2, 1));
        push(which, mk(n, nxt, 0, 27));
    endfunction

    task automatic advance();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic wait_tick(output bit ok);
        ok = tick2;
        for (int i = 0; i < 3 * TDIV && !ok; i++) begin
            @(posedge clk_50M);
            #1;
            ok = tick2;
        end
    endtask

    task automatic do_reset();
        advance();
        reset_n = 1'b0;
        demand2 = '0;
        demand4 = '0;
        demand1 = '0;
        advance();
        advance();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        advance();
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs2() !== mk(2, 0, 0, 27)) begin
            failures++;
            $display("FAIL reset_dut2 got=%h exp=%h", obs2(), mk(2, 0, 0, 27));
        end
        checks++;
        if (obs4() !== mk(4, 0, 0, 27)) begin
            failures++;
            $display("FAIL reset_dut4 got=%h exp=%h", obs4(), mk(4, 0, 0, 27));
        end
        checks++;
        if (obs1() !== mk(1, 0, 0, 27)) begin
            failures++;
            $display("FAIL reset_dut1 got=%h exp=%h", obs1(), mk(1, 0, 0, 27));
        end
        advance();
        reset_n = 1'b1;
        n = 0;
        while (!tick2 && n < 3 * TDIV) begin
            advance();
            n++;
        end
        checks++;
        if (n != TDIV - 1) begin
            failures++;
            $display("FAIL first_tick_edge got=%0d exp=%0d", n, TDIV - 1);
        end
        advance();
        checks++;
        if (tick2 !== 1'b0) begin
            failures++;
            $display("FAIL tick_width got=%b exp=0", tick2);
        end
    endtask

    task automatic test_rest_in_green();
        bit ok;
        logic [36:0] e;
        do_reset();
        demand1 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            push(2, mk(2, 0, 0, 27 - (k % 27)));
            push(1, mk(1, 0, 0, 27 - (k % 27)));
        end
        for (int k = 1; k <= 60; k++) begin
            wait_tick(ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL rest_tick_timeout tick=%0d got=none exp=tick", k);
            end
            advance();
            e = q2.pop_front();
            checks++;
            if (obs2() !== e) begin
                failures++;
                $display("FAIL rest_green tick=%0d got=%h exp=%h", k, obs2(), e);
            end
            e = q1.pop_front();
            checks++;
            if (obs1() !== e) begin
                failures++;
                $display("FAIL single_phase tick=%0d got=%h exp=%h", k, obs1(), e);
            end
        end
    endtask

    task automatic test_handover();
        bit ok;
        logic [36:0] e;
        do_reset();
        push_serve(2, 2, 0, 1);
        push(2, mk(2, 1, 0, 26));
        for (int k = 1; k <= 32; k++) begin
            wait_tick(ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL handover_tick_timeout tick=%0d got=none exp=tick", k);
            end
            advance();
            e = q2.pop_front();
            checks++;
            if (obs2() !== e) begin
                failures++;
                $display("FAIL handover tick=%0d got=%h exp=%h", k, obs2(), e);
            end
            if (k == 4) begin
                demand2 = 2'b10;
                advance();
                demand2 = 2'b00;
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [36:0] e;
        do_reset();
        push_serve(4, 4, 0, 1);
        push_serve(4, 4, 1, 3);
        push_serve(4, 4, 3, 0);
        for (int k = 1; k <= 93; k++) begin
            wait_tick(ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL rr_tick_timeout tick=%0d got=none exp=tick", k);
            end
            advance();
            e = q4.pop_front();
            checks++;
            if (obs4() !== e) begin
                failures++;
                $display("FAIL round_robin tick=%0d got=%h exp=%h", k, obs4(), e);
            end
            if (k == 1 || k == 35) begin
                demand4 = (k == 1) ? 4'b0010 : 4'b1001;
                advance();
                demand4 = 4'b0000;
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        bit ok;
        int n;
        do_reset();
        for (int k = 1; k <= 58; k++) begin
            wait_tick(ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL midy_tick_timeout tick=%0d got=none exp=tick", k);
            end
            advance();
            if (k == 1 || k == 32) begin
                demand2 = (k == 1) ? 2'b10 : 2'b01;
                advance();
                demand2 = 2'b00;
            end
        end
        checks++;
        if (obs2() !== mk(2, 1, 1, 3)) begin
            failures++;
            $display("FAIL midy_in_yellow got=%h exp=%h", obs2(), mk(2, 1, 1, 3));
        end
        advance();
        advance();
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs2() !== mk(2, 0, 0, 27)) begin
            failures++;
            $display("FAIL midy_async_reset got=%h exp=%h", obs2(), mk(2, 0, 0, 27));
        end
        advance();
        reset_n = 1'b1;
        n = 0;
        while (!tick2 && n < 3 * TDIV) begin
            advance();
            n++;
        end
        checks++;
        if (n != TDIV - 1) begin
            failures++;
            $display("FAIL midy_prescaler_restart got=%0d exp=%0d", n, TDIV - 1);
        end
        advance();
        checks++;
        if (obs2() !== mk(2, 0, 0, 26)) begin
            failures++;
            $display("FAIL midy_after_reset got=%h exp=%h", obs2(), mk(2, 0, 0, 26));
        end
    endtask

    task automatic test_expiry_demand();
        bit ok;
        logic [36:0] e;
        do_reset();
        for (int c = 26; c >= 1; c--) push(2, mk(2, 0, 0, c));
        push(2, mk(2, 0, 1, 3));
        for (int k = 1; k <= 27; k++) begin
            wait_tick(ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL expiry_tick_timeout tick=%0d got=none exp=tick", k);
            end
            if (k == 27) demand2 = 2'b10;
            advance();
            demand2 = 2'b00;
            e = q2.pop_front();
            checks++;
            if (obs2() !== e) begin
                failures++;
                $display("FAIL expiry_demand tick=%0d got=%h exp=%h", k, obs2(), e);
            end
        end
    endtask

    task automatic test_gapout();
        bit ok;
        logic [36:0] e;
        do_reset();
        for (int c = 26; c >= 20; c--) push(2, mk(2, 0, 0, c));
`ifdef EARLY_GAPOUT_EN
        for (int c = 5; c >= 1; c--) push(2, mk(2, 0, 0, c));
        push(2, mk(2, 0, 1, 3));
`else
        for (int c = 19; c >= 14; c--) push(2, mk(2, 0, 0, c));
`endif
        for (int k = 1; k <= 13; k++) begin
            wait_tick(ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL gap_tick_timeout tick=%0d got=none exp=tick", k);
            end
            advance();
            e = q2.pop_front();
            checks++;
            if (obs2() !== e) begin
                failures++;
                $display("FAIL gapout tick=%0d got=%h exp=%h", k, obs2(), e);
            end
            if (k == 7) demand2 = 2'b10;
            if (k == 8) demand2 = 2'b00;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        demand2 = '0;
        demand4 = '0;
        demand1 = '0;
        test_reset();
        test_rest_in_green();
        test_handover();
        test_round_robin();
        test_reset_mid_yellow();
        test_expiry_demand();
        test_gapout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
